// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main control FSM.
// State codes, opcode constants, ALUOp codes and datapath mux select codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JR       = 4'd12
  } state_t;

  typedef enum logic [2:0] {
    CL_R, CL_MEM, CL_BRANCH, CL_JUMP, CL_IMM, CL_ILL
  } op_class_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_XOR   = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_FUNCT = 3'b110;
  localparam logic [2:0] ALU_SLTU  = 3'b111;

  localparam logic [1:0] PCSRC_ALU = 2'b00, PCSRC_ALUOUT = 2'b01, PCSRC_JUMP = 2'b10, PCSRC_REGA = 2'b11;
  localparam logic [1:0] SRCA_PC = 2'b00, SRCA_REGA = 2'b01, SRCA_SHAMT = 2'b10;
  localparam logic [1:0] SRCB_REGB = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SL2 = 2'b11;
  localparam logic [1:0] DST_RT = 2'b00, DST_RD = 2'b01, DST_RA = 2'b10;
  localparam logic [1:0] WB_ALUOUT = 2'b00, WB_MDR = 2'b01, WB_PC = 2'b10;

endpackage

// File: rtl/mips_op_decode.sv
// Combinational opcode classifier: instruction class, immediate ALUOp and
// the few per-opcode flags the control FSM needs after DECODE.
module mips_op_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output op_class_t  op_class,
  output logic [2:0] imm_alu_op,
  output logic       is_bne,
  output logic       is_jal,
  output logic       is_sw,
  output logic       illegal
);

  always_comb begin
    op_class   = CL_ILL;
    imm_alu_op = ALU_ADD;
    case (opcode)
      OP_RTYPE:      op_class = CL_R;
      OP_LW, OP_SW:  op_class = CL_MEM;
      OP_BEQ, OP_BNE: op_class = CL_BRANCH;
      OP_J, OP_JAL:  op_class = CL_JUMP;
      OP_ADDI:  begin op_class = CL_IMM; imm_alu_op = ALU_ADD;  end
      OP_ANDI:  begin op_class = CL_IMM; imm_alu_op = ALU_AND;  end
      OP_ORI:   begin op_class = CL_IMM; imm_alu_op = ALU_OR;   end
      OP_XORI:  begin op_class = CL_IMM; imm_alu_op = ALU_XOR;  end
      OP_SLTI:  begin op_class = CL_IMM; imm_alu_op = ALU_SLT;  end
      OP_SLTIU: begin op_class = CL_IMM; imm_alu_op = ALU_SLTU; end
      default:  op_class = CL_ILL;
    endcase
  end

  assign is_bne  = (opcode == OP_BNE);
  assign is_jal  = (opcode == OP_JAL);
  assign is_sw   = (opcode == OP_SW);
  assign illegal = (op_class == CL_ILL);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: fetch/decode/execute/mem/writeback
// sequencing, datapath selects, and a bounded-wait handshake with unified memory.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       jr,
  input  logic       shamt,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       illegal,
  output logic       mem_err,
  output logic [3:0] state_dbg
);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             abort_q;

  op_class_t  op_class;
  logic [2:0] imm_alu_op;
  logic       is_bne, is_jal, is_sw, dec_illegal;

  mips_op_decode u_dec (
    .opcode     (opcode),
    .op_class   (op_class),
    .imm_alu_op (imm_alu_op),
    .is_bne     (is_bne),
    .is_jal     (is_jal),
    .is_sw      (is_sw),
    .illegal    (dec_illegal)
  );

  // Handshake: mem_req is held high in a memory state until a cycle where
  // mem_ready is also high (the access completes in that cycle) or the wait
  // limit expires; after an abort mem_req stays low for one cycle.
  logic req_active, mem_done, timeout;
  assign req_active = (state inside {S_FETCH, S_MEM_RD, S_MEM_WR}) && !abort_q;
  assign mem_done   = req_active && mem_ready;
  assign timeout    = req_active && !mem_ready && (wait_cnt == CNT_W'(MEM_WAIT_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      abort_q  <= 1'b0;
    end else begin
      abort_q <= timeout;
      if (mem_done || timeout) wait_cnt <= '0;
      else if (req_active)     wait_cnt <= wait_cnt + 1'b1;
      case (state)
        S_FETCH:    if (mem_done) state <= S_DECODE;
        S_DECODE: begin
          case (op_class)
            CL_R:      state <= S_R_EXEC;
            CL_MEM:    state <= S_MEM_ADDR;
            CL_BRANCH: state <= S_BRANCH;
            CL_JUMP:   state <= S_JUMP;
            CL_IMM:    state <= S_I_EXEC;
            default:   state <= S_FETCH;
          endcase
        end
        S_MEM_ADDR: state <= is_sw ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD: begin
          if (mem_done)     state <= S_MEM_WB;
          else if (timeout) state <= S_FETCH;
        end
        S_MEM_WR:   if (mem_done || timeout) state <= S_FETCH;
        S_R_EXEC:   state <= jr ? S_JR : S_R_WB;
        S_I_EXEC:   state <= S_I_WB;
        default:    state <= S_FETCH;
      endcase
    end
  end

  assign state_dbg = state;

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PCSRC_ALU;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_REGB;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    reg_dst    = DST_RT;
    mem_to_reg = WB_ALUOUT;
    illegal    = 1'b0;
    mem_err    = timeout;
    case (state)
      S_FETCH: begin
        mem_req   = !abort_q;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_done;
        pc_write  = mem_done;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SL2;
        illegal   = dec_illegal;
      end
      S_MEM_ADDR: begin
        alu_src_a = SRCA_REGA;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = WB_MDR;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
      end
      S_R_EXEC: begin
        alu_op    = ALU_FUNCT;
        alu_src_a = shamt ? SRCA_SHAMT : SRCA_REGA;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = DST_RD;
      end
      S_JR: begin
        pc_write = 1'b1;
        pc_src   = PCSRC_REGA;
      end
      S_I_EXEC: begin
        alu_src_a = SRCA_REGA;
        alu_src_b = SRCB_IMM;
        alu_op    = imm_alu_op;
      end
      S_I_WB:     reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = SRCA_REGA;
        alu_op    = ALU_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_write  = is_bne ? !zero : zero;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PCSRC_JUMP;
        if (is_jal) begin
          reg_write  = 1'b1;
          reg_dst    = DST_RA;
          mem_to_reg = WB_PC;
        end
      end
      default: ;
    endcase
    // While reset is held only the fetch request is visible; no state updates leak out.
    if (!rst_n) begin
      mem_we = 1'b0; iord = 1'b0; ir_write = 1'b0; pc_write = 1'b0;
      pc_src = 2'b00; alu_src_a = 2'b00; alu_src_b = 2'b00; alu_op = 3'b000;
      reg_write = 1'b0; reg_dst = 2'b00; mem_to_reg = 2'b00;
      illegal = 1'b0; mem_err = 1'b0; mem_req = 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-instruction cycle model builds expected
// output vectors; one loop drives each cycle and compares every output.
module tb_mips_multicycle_ctrl;

  localparam int W = 21;
  localparam int MEM_WAIT_MAX = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic       jr = 1'b0, shamt = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic       mem_req, mem_we, iord, ir_write, pc_write;
  logic [1:0] pc_src, alu_src_a, alu_src_b, reg_dst, mem_to_reg;
  logic [2:0] alu_op;
  logic       reg_write, illegal, mem_err;
  logic [3:0] state_dbg;

  mips_multicycle_ctrl #(.MEM_WAIT_MAX(MEM_WAIT_MAX), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .jr(jr), .shamt(shamt),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .iord(iord), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal(illegal), .mem_err(mem_err), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] act;
  assign act = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
                alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, illegal, mem_err};

  logic [W-1:0] exp_q[$];
  logic [9:0]   stim_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // ---------------- model ----------------
  function automatic logic [W-1:0] ov(input logic req, we, io, irw, pcw,
                                      input logic [1:0] pcs, sa, sb,
                                      input logic [2:0] aop,
                                      input logic rw,
                                      input logic [1:0] rd, m2r,
                                      input logic ill, merr);
    return {req, we, io, irw, pcw, pcs, sa, sb, aop, rw, rd, m2r, ill, merr};
  endfunction

  function automatic logic legal_op(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                      6'b000010, 6'b000011, 6'b001000, 6'b001100, 6'b001101,
                      6'b001110, 6'b001010, 6'b001011};
  endfunction

  function automatic logic [2:0] imm_aop(input logic [5:0] op);
    case (op)
      6'b001100: return 3'b010;
      6'b001101: return 3'b011;
      6'b001110: return 3'b100;
      6'b001010: return 3'b101;
      6'b001011: return 3'b111;
      default:   return 3'b000;
    endcase
  endfunction

  task automatic push(input logic [5:0] op, input logic j, s, z, r, input logic [W-1:0] e);
    stim_q.push_back({op, j, s, z, r});
    exp_q.push_back(e);
  endtask

  // After an aborted access: fetch selects, request low, ready ignored.
  task automatic push_abort(input logic [5:0] op, input logic j, s, z);
    push(op, j, s, z, 1'b1, ov(0,0,0,0,0, 2'b00,2'b00,2'b01, 3'b000, 0, 2'b00,2'b00, 0,0));
  endtask

  task automatic fetch_phase(input logic [5:0] op, input logic j, s, z, input int fw, output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= MEM_WAIT_MAX; i++) begin
      if (i >= fw) begin
        push(op, j, s, z, 1'b1, ov(1,0,0,1,1, 2'b00,2'b00,2'b01, 3'b000, 0, 2'b00,2'b00, 0,0));
        ok = 1'b1;
        return;
      end
      if (i == MEM_WAIT_MAX) begin
        push(op, j, s, z, 1'b0, ov(1,0,0,0,0, 2'b00,2'b00,2'b01, 3'b000, 0, 2'b00,2'b00, 0,1));
        push_abort(op, j, s, z);
        return;
      end
      push(op, j, s, z, 1'b0, ov(1,0,0,0,0, 2'b00,2'b00,2'b01, 3'b000, 0, 2'b00,2'b00, 0,0));
    end
  endtask

  task automatic data_phase(input logic [5:0] op, input logic we, input int mw, output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= MEM_WAIT_MAX; i++) begin
      if (i >= mw) begin
        push(op, 0, 0, 0, 1'b1, ov(1,we,1,0,0, 2'b00,2'b00,2'b00, 3'b000, 0, 2'b00,2'b00, 0,0));
        ok = 1'b1;
        return;
      end
      if (i == MEM_WAIT_MAX) begin
        push(op, 0, 0, 0, 1'b0, ov(1,we,1,0,0, 2'b00,2'b00,2'b00, 3'b000, 0, 2'b00,2'b00, 0,1));
        push_abort(op, 0, 0, 0);
        return;
      end
      push(op, 0, 0, 0, 1'b0, ov(1,we,1,0,0, 2'b00,2'b00,2'b00, 3'b000, 0, 2'b00,2'b00, 0,0));
    end
  endtask

  // Whole instruction: fw/mw = cycles memory withholds mem_ready in fetch / data access.
  task automatic instr(input logic [5:0] op, input logic j, s, z, input int fw, mw);
    bit ok;
    fetch_phase(op, j, s, z, fw, ok);
    if (!ok) return;
    push(op, j, s, z, 1'b1, ov(0,0,0,0,0, 2'b00,2'b00,2'b11, 3'b000, 0, 2'b00,2'b00, !legal_op(op),0));
    if (!legal_op(op)) return;
    case (op)
      6'b000000: begin
        push(op, j, s, z, 1'b1, ov(0,0,0,0,0, 2'b00, s ? 2'b10 : 2'b01, 2'b00, 3'b110, 0, 2'b00,2'b00, 0,0));
        if (j) push(op, j, s, z, 1'b1, ov(0,0,0,0,1, 2'b11,2'b00,2'b00, 3'b000, 0, 2'b00,2'b00, 0,0));
        else   push(op, j, s, z, 1'b1, ov(0,0,0,0,0, 2'b00,2'b00,2'b00, 3'b000, 1, 2'b01,2'b00, 0,0));
      end
      6'b100011, 6'b101011: begin
        push(op, j, s, z, 1'b1, ov(0,0,0,0,0, 2'b00,2'b01,2'b10, 3'b000, 0, 2'b00,2'b00, 0,0));
        data_phase(op, op == 6'b101011, mw, ok);
        if (ok && op == 6'b100011)
          push(op, j, s, z, 1'b1, ov(0,0,0,0,0, 2'b00,2'b00,2'b00, 3'b000, 1, 2'b00,2'b01, 0,0));
      end
      6'b000100, 6'b000101:
        push(op, j, s, z, 1'b1, ov(0,0,0,0, (op == 6'b000100) ? z : !z, 2'b01,2'b01,2'b00,
                                   3'b001, 0, 2'b00,2'b00, 0,0));
      6'b000010:
        push(op, j, s, z, 1'b1, ov(0,0,0,0,1, 2'b10,2'b00,2'b00, 3'b000, 0, 2'b00,2'b00, 0,0));
      6'b000011:
        push(op, j, s, z, 1'b1, ov(0,0,0,0,1, 2'b10,2'b00,2'b00, 3'b000, 1, 2'b10,2'b10, 0,0));
      default: begin
        push(op, j, s, z, 1'b1, ov(0,0,0,0,0, 2'b00,2'b01,2'b10, imm_aop(op), 0, 2'b00,2'b00, 0,0));
        push(op, j, s, z, 1'b1, ov(0,0,0,0,0, 2'b00,2'b00,2'b00, 3'b000, 1, 2'b00,2'b00, 0,0));
      end
    endcase
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, want);
    end
  endtask

  // Drives one queued cycle after each rising edge, compares at the falling edge.
  task automatic drain();
    logic [9:0]   s;
    logic [W-1:0] e;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      {opcode, jr, shamt, zero, mem_ready} = s;
      @(negedge clk);
      cyc++;
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL cycle%0d outputs got %b expected %b", cyc, act, e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  localparam logic [W-1:0] RST_V = {1'b1, 20'b0};

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    mem_ready = 1'b1;
    opcode = 6'b100011;
    #1;
    chk("reset_outputs", 32'(act), 32'(RST_V));
    rst_n = 1'b1;
    #1;

    // model pins against hand-derived cycle counts and fields
    instr(6'b000000, 0, 0, 0, 0, 0);
    chk("pin_add_len", exp_q.size(), 4);
    chk("pin_add_aluop", 32'(exp_q[2][9:7]), 32'h6);
    chk("pin_add_rdst", 32'(exp_q[3][5:4]), 32'h1);
    drain();
    instr(6'b000000, 0, 1, 0, 0, 0);
    chk("pin_sll_srca", 32'(exp_q[2][13:12]), 32'h2);
    drain();
    instr(6'b000000, 1, 0, 0, 0, 0);
    chk("pin_jr_pcsrc", 32'(exp_q[3][15:14]), 32'h3);
    drain();
    instr(6'b100011, 0, 0, 0, 0, 3);
    chk("pin_lw_wait_len", exp_q.size(), 8);
    chk("pin_lw_m2r", 32'(exp_q[7][3:2]), 32'h1);
    drain();
    instr(6'b100011, 0, 0, 0, 0, 0);
    chk("pin_lw_len", exp_q.size(), 5);
    drain();
    instr(6'b101011, 0, 0, 0, 0, 0);
    chk("pin_sw_len", exp_q.size(), 4);
    drain();
    instr(6'b000100, 0, 0, 1, 0, 0);
    chk("pin_beq_len", exp_q.size(), 3);
    chk("pin_beq_pcw", 32'(exp_q[2][16]), 32'h1);
    drain();
    instr(6'b000100, 0, 0, 0, 2, 0);
    instr(6'b000101, 0, 0, 1, 0, 0);
    instr(6'b000101, 0, 0, 0, 1, 0);
    instr(6'b000010, 0, 0, 0, 0, 0);
    instr(6'b000011, 0, 0, 1, 0, 0);
    instr(6'b001000, 0, 0, 0, 0, 0);
    instr(6'b001100, 0, 0, 0, 0, 0);
    instr(6'b001101, 0, 0, 0, 0, 0);
    instr(6'b001110, 0, 0, 0, 0, 0);
    instr(6'b001010, 0, 0, 0, 0, 0);
    instr(6'b001011, 0, 0, 0, 0, 0);
    drain();
    instr(6'b111111, 0, 0, 0, 0, 0);
    chk("pin_illegal_len", exp_q.size(), 2);
    drain();
    instr(6'b000001, 0, 0, 0, 0, 0);
    drain();
    // fetch never answered, then answered exactly at the limit
    instr(6'b000000, 0, 0, 0, 16, 0);
    chk("pin_timeout_len", exp_q.size(), 17);
    chk("pin_timeout_err", 32'(exp_q[15][0]), 32'h1);
    drain();
    instr(6'b000000, 0, 0, 0, 15, 0);
    chk("pin_limit_len", exp_q.size(), 19);
    drain();
    instr(6'b101011, 0, 0, 0, 0, 16);
    instr(6'b100011, 0, 0, 0, 1, 16);
    instr(6'b100011, 0, 0, 0, 0, 5);
    drain();

    // reset asserted mid-way through a store
    push(6'b101011, 0, 0, 0, 1'b1, ov(1,0,0,1,1, 2'b00,2'b00,2'b01, 3'b000, 0, 2'b00,2'b00, 0,0));
    push(6'b101011, 0, 0, 0, 1'b1, ov(0,0,0,0,0, 2'b00,2'b00,2'b11, 3'b000, 0, 2'b00,2'b00, 0,0));
    push(6'b101011, 0, 0, 0, 1'b1, ov(0,0,0,0,0, 2'b00,2'b01,2'b10, 3'b000, 0, 2'b00,2'b00, 0,0));
    push(6'b101011, 0, 0, 0, 1'b0, ov(1,1,1,0,0, 2'b00,2'b00,2'b00, 3'b000, 0, 2'b00,2'b00, 0,0));
    drain();
    mem_ready = 1'b0;
    #2;
    chk("pre_reset_mem_we", 32'(mem_we), 32'h1);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("async_reset_outputs", 32'(act), 32'(RST_V));
    @(negedge clk);
    chk("held_reset_outputs", 32'(act), 32'(RST_V));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    instr(6'b000000, 0, 0, 0, 0, 0);
    instr(6'b000011, 0, 0, 0, 3, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
